// File: rtl/gpdout_arb_if.sv
// Request/write-port bundle between the GP data-out arbiter and its requesters.
// The master side is the requester cluster (and sees the register write port),
// the slave side is the arbiter itself.
interface gpdout_arb_if #(
  parameter int NREQ = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_lock;
  logic [4*NREQ-1:0]  req_wen;
  logic [32*NREQ-1:0] req_data;
  logic               out_en;
  logic [3:0]         out_wen;
  logic [31:0]        out_dout;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  modport master (
    output req_valid, req_lock, req_wen, req_data,
    input  req_ready, out_en, out_wen, out_dout, grant_id, busy
  );

  modport slave (
    input  req_valid, req_lock, req_wen, req_data,
    output req_ready, out_en, out_wen, out_dout, grant_id, busy
  );
endinterface

// File: rtl/gpdout_arb.sv
// Round-robin arbiter in front of the single GP data-out register write port.
// One beat is accepted per cycle; the accepted beat is presented on out_* one
// cycle later. A requester may lock the grant for a short burst, bounded both
// by a beat count and by an idle timeout so a stalled owner cannot starve others.
module gpdout_arb #(
  parameter int NREQ         = 2,
  parameter int LOCK_MAX     = 4,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  gpdout_arb_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] ID_ZERO = IDW'(0);
  localparam logic [IDW-1:0] ID_ONE  = IDW'(1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_r, state_n;
  logic [IDW-1:0]  ptr_r, ptr_n;
  logic [IDW-1:0]  owner_r, owner_n;
  logic [3:0]      beat_r, beat_n;
  logic [7:0]      idle_r, idle_n;

  logic            hi_found_s, lo_found_s;
  logic [IDW-1:0]  hi_id_s, lo_id_s;
  logic            sel_found_s;
  logic [IDW-1:0]  sel_id_s;
  logic [NREQ-1:0] req_ready_s;
  logic            sel_lock_s;
  logic [3:0]      sel_wen_s;
  logic [31:0]     sel_data_s;

  logic            out_en_r;
  logic [3:0]      out_wen_r;
  logic [31:0]     out_dout_r;
  logic [IDW-1:0]  grant_id_r;
  logic            busy_r;

  // Successor of a requester index, wrapping at NREQ.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    logic [IDW-1:0] nxt;
    if (id >= ID_LAST) begin
      nxt = ID_ZERO;
    end else begin
      nxt = id + ID_ONE;
    end
    return nxt;
  endfunction

  // Lowest valid requester at/above ptr and lowest valid requester below ptr.
  always_comb begin
    hi_found_s = 1'b0;
    hi_id_s    = ID_ZERO;
    lo_found_s = 1'b0;
    lo_id_s    = ID_ZERO;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        if (IDW'(k) >= ptr_r) begin
          hi_found_s = 1'b1;
          hi_id_s    = IDW'(k);
        end else begin
          lo_found_s = 1'b1;
          lo_id_s    = IDW'(k);
        end
      end else begin
        hi_found_s = hi_found_s;
      end
    end
  end

  // Pick the requester that transfers this cycle; the owner is the only candidate while locked.
  always_comb begin
    sel_found_s = 1'b0;
    sel_id_s    = ID_ZERO;
    if (reset) begin
      sel_found_s = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      sel_found_s = bus.req_valid[owner_r];
      sel_id_s    = owner_r;
    end else if (hi_found_s) begin
      sel_found_s = 1'b1;
      sel_id_s    = hi_id_s;
    end else if (lo_found_s) begin
      sel_found_s = 1'b1;
      sel_id_s    = lo_id_s;
    end else begin
      sel_found_s = 1'b0;
    end
  end

  // Ready decode and mux of the selected requester's lock/wen/data.
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    sel_lock_s  = 1'b0;
    sel_wen_s   = 4'b0000;
    sel_data_s  = 32'h0000_0000;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_id_s == IDW'(k)) begin
        req_ready_s[k] = sel_found_s;
        sel_lock_s     = bus.req_lock[k];
        sel_wen_s      = bus.req_wen[4*k +: 4];
        sel_data_s     = bus.req_data[32*k +: 32];
      end else begin
        req_ready_s[k] = 1'b0;
      end
    end
  end

  // Arbitration state: pointer advance, lock entry, beat limit and idle timeout.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    beat_n  = beat_r;
    idle_n  = idle_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          ptr_n = next_id(sel_id_s);
          if (sel_lock_s && (LOCK_MAX > 1)) begin
            state_n = ST_LOCKED;
            owner_n = sel_id_s;
            beat_n  = 4'd1;
            idle_n  = 8'd0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (sel_found_s) begin
          beat_n = beat_r + 4'd1;
          idle_n = 8'd0;
          if (!sel_lock_s || (beat_r + 4'd1 == 4'(LOCK_MAX))) begin
            state_n = ST_IDLE;
            ptr_n   = next_id(owner_r);
          end else begin
            state_n = ST_LOCKED;
          end
        end else begin
          idle_n = idle_r + 8'd1;
          if (idle_r + 8'd1 == 8'(LOCK_TIMEOUT)) begin
            state_n = ST_IDLE;
            ptr_n   = next_id(owner_r);
          end else begin
            state_n = ST_LOCKED;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= ID_ZERO;
      owner_r <= ID_ZERO;
      beat_r  <= 4'd0;
      idle_r  <= 8'd0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      beat_r  <= beat_n;
      idle_r  <= idle_n;
    end
  end

  // Output stage: a beat with any byte enabled becomes a one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_en_r   <= 1'b0;
      out_wen_r  <= 4'b0000;
      out_dout_r <= 32'h0000_0000;
      grant_id_r <= ID_ZERO;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= (state_n == ST_LOCKED);
      if (sel_found_s && (sel_wen_s != 4'b0000)) begin
        out_en_r   <= 1'b1;
        out_wen_r  <= sel_wen_s;
        out_dout_r <= sel_data_s;
        grant_id_r <= sel_id_s;
      end else begin
        out_en_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_en    = out_en_r;
  assign bus.out_wen   = out_wen_r;
  assign bus.out_dout  = out_dout_r;
  assign bus.grant_id  = grant_id_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_gpdout_arb.sv
// Bench for gpdout_arb: directed scenarios followed by random traffic, all
// checked cycle by cycle against a rule-level model of the arbiter.
module tb_gpdout_arb;
  localparam int NREQ         = 2;
  localparam int LOCK_MAX     = 4;
  localparam int LOCK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  gpdout_arb_if #(.NREQ(NREQ)) bus ();

  gpdout_arb #(
    .NREQ(NREQ),
    .LOCK_MAX(LOCK_MAX),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_known  = 1'b0;
  bit          m_locked = 1'b0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  int          m_beats  = 0;
  int          m_idle   = 0;
  bit          m_en     = 1'b0;
  logic [3:0]  m_wen    = 4'h0;
  logic [31:0] m_dout   = 32'h0;
  int          m_gid    = 0;
  bit          m_busy   = 1'b0;
  int          last_g   = -1;
  int          stall;
  int          t4_exp [6] = '{0, 0, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which requester the rules say transfers now (-1 = none).
  function automatic int pick();
    if (reset) return -1;
    if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int j = (m_ptr + k) % NREQ;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (reset) begin
      m_known  = 1'b1;
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      m_beats  = 0;
      m_idle   = 0;
      m_en     = 1'b0;
      m_wen    = 4'h0;
      m_dout   = 32'h0;
      m_gid    = 0;
    end else if (g >= 0) begin
      if (bus.req_wen[4*g +: 4] != 4'h0) begin
        m_en   = 1'b1;
        m_wen  = bus.req_wen[4*g +: 4];
        m_dout = bus.req_data[32*g +: 32];
        m_gid  = g;
      end else begin
        m_en = 1'b0;
      end
      if (!m_locked) begin
        m_ptr = (g + 1) % NREQ;
        if (bus.req_lock[g] && LOCK_MAX > 1) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_beats  = 1;
          m_idle   = 0;
        end
      end else begin
        m_beats++;
        m_idle = 0;
        if (!bus.req_lock[g] || m_beats == LOCK_MAX) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % NREQ;
        end
      end
    end else begin
      m_en = 1'b0;
      if (m_locked) begin
        m_idle++;
        if (m_idle == LOCK_TIMEOUT) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % NREQ;
        end
      end
    end
    m_busy = m_locked;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    last_g = pick();
    chk("ready", bus.req_ready, (last_g >= 0) ? (64'd1 << last_g) : 64'd0);
    if (m_known) begin
      chk("out_en", bus.out_en, m_en);
      chk("out_wen", bus.out_wen, m_wen);
      chk("out_dout", bus.out_dout, m_dout);
      chk("grant_id", bus.grant_id, m_gid);
      chk("busy", bus.busy, m_busy);
    end
    model_edge(last_g);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input bit lk, input logic [3:0] w, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_lock[i]           = lk;
    bus.req_wen[4*i +: 4]     = w;
    bus.req_data[32*i +: 32]  = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    // 1: reset held with every requester valid
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b0, 4'hF, $urandom);
    repeat (3) cycle();
    chk("t1_en", bus.out_en, 1'b0);
    chk("t1_dout", bus.out_dout, 32'h0);
    chk("t1_busy", bus.busy, 1'b0);

    // 2: single beat
    reset = 1'b0;
    idle_all();
    drive(0, 1'b1, 1'b0, 4'b0001, 32'h0000_00A5);
    cycle();
    chk("t2_gnt", last_g, 0);
    chk("t2_en", bus.out_en, 1'b1);
    chk("t2_wen", bus.out_wen, 4'b0001);
    chk("t2_dout", bus.out_dout, 32'h0000_00A5);
    chk("t2_gid", bus.grant_id, 0);
    idle_all();
    cycle();
    chk("t2_en_off", bus.out_en, 1'b0);

    // 3: round robin with both requesters valid
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 4'hF, $urandom);
    drive(1, 1'b1, 1'b0, 4'hF, $urandom);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_gnt", last_g, k % 2);
      chk("t3_en", bus.out_en, 1'b1);
    end

    // 4: locked burst capped at LOCK_MAX beats
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(0, 1'b1, 1'b1, 4'hF, $urandom);
    drive(1, 1'b1, 1'b0, 4'hF, $urandom);
    for (int k = 0; k < 6; k++) begin
      chk("t4_busy", bus.busy, (k >= 1 && k <= 3));
      cycle();
      chk("t4_gnt", last_g, t4_exp[k]);
    end

    // 5: lock timeout while the owner goes quiet
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle_all();
    drive(0, 1'b1, 1'b1, 4'hF, $urandom);
    cycle();
    chk("t5_lock", last_g, 0);
    idle_all();
    drive(1, 1'b1, 1'b0, 4'hF, $urandom);
    stall = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_g == 1) break;
      stall++;
    end
    chk("t5_stall", stall, LOCK_TIMEOUT);

    // 6: zero-enable beat, then a written beat followed by reset
    idle_all();
    drive(0, 1'b1, 1'b0, 4'h0, $urandom);
    cycle();
    chk("t6_gnt", last_g, 0);
    chk("t6_en", bus.out_en, 1'b0);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h1234_5678);
    cycle();
    reset = 1'b1;
    idle_all();
    cycle();
    reset = 1'b0;
    chk("t6_en_rst", bus.out_en, 1'b0);
    chk("t6_dout_rst", bus.out_dout, 32'h0);
    cycle();

    // Random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        drive(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom), $urandom);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
